// File: rtl/count_updn_if.sv
// count_updn_if: control/status bundle for the count_updn counter.
//   master: drives en, up, clear, load, load_val; observes out, tc, wrap, ovf
//   slave : the counter itself
interface count_updn_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, clear, load, load_val,
    input  out, tc, wrap, ovf
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output out, tc, wrap, ovf
  );
endinterface

// File: rtl/count_updn.sv
// count_updn: parametrised up/down counter with modulus MAX+1, count enable,
// parallel load (clamped to MAX), synchronous clear, wrap or saturate mode.
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      count_updn_if.slave:
//            en, up, clear, load, load_val -> controls
//            out  current count
//            tc   out at the end of the range in the live direction
//            wrap registered pulse in the cycle showing a post-wrap/saturate value
//            ovf  sticky wrap/saturate flag, cleared by reset or clear
module count_updn #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  count_updn_if.slave bus
);

  localparam logic [WIDTH:0] MAX_X = {1'b0, MAX};
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_q;
  logic             wrap_q;
  logic             ovf_q;

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic             at_max;
  logic             at_zero;
  logic             hit_end;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

  // One extra bit lets the increment overshoot and the decrement borrow be
  // seen directly, so end-of-range detection never relies on WIDTH-bit rollover.
  always_comb begin
    cnt_x    = {1'b0, out_q};
    inc_x    = cnt_x + ONE_X;
    dec_x    = cnt_x - ONE_X;
    at_max   = (inc_x > MAX_X);
    at_zero  = dec_x[WIDTH];
    hit_end  = 1'b0;
    step_val = out_q;
    if (bus.up) begin
      if (at_max) begin
        hit_end  = 1'b1;
        step_val = SATURATE ? MAX : '0;
      end else begin
        step_val = inc_x[WIDTH-1:0];
      end
    end else begin
      if (at_zero) begin
        hit_end  = 1'b1;
        step_val = SATURATE ? '0 : MAX;
      end else begin
        step_val = dec_x[WIDTH-1:0];
      end
    end
    load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.clear) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.load) begin
      out_q  <= load_clamped;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      out_q  <= step_val;
      wrap_q <= hit_end;
      if (hit_end) begin
        ovf_q <= 1'b1;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // tc tracks the live direction so it can be polled while the counter idles.
  assign bus.out  = out_q;
  assign bus.tc   = bus.up ? at_max : at_zero;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_count_updn.sv
module tb_count_updn;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, clear, load;
  logic [3:0] load_val;

  always #5 clk = ~clk;

  // Three configurations driven by one shared stimulus stream:
  //   0: WIDTH=4, MAX=15, wrap   1: MAX=9, wrap   2: MAX=9, saturate
  count_updn_if #(.WIDTH(4)) b0 ();
  count_updn_if #(.WIDTH(4)) b1 ();
  count_updn_if #(.WIDTH(4)) b2 ();

  count_updn #(.WIDTH(4))                                u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  count_updn #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0))   u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  count_updn #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1))   u2 (.clk(clk), .reset_n(reset_n), .bus(b2));

  assign b0.en = en;  assign b0.up = up;  assign b0.clear = clear;  assign b0.load = load;  assign b0.load_val = load_val;
  assign b1.en = en;  assign b1.up = up;  assign b1.clear = clear;  assign b1.load = load;  assign b1.load_val = load_val;
  assign b2.en = en;  assign b2.up = up;  assign b2.clear = clear;  assign b2.load = load;  assign b2.load_val = load_val;

  logic [3:0] d_out [3];
  logic       d_tc [3];
  logic       d_wrap [3];
  logic       d_ovf [3];
  assign d_out[0] = b0.out;  assign d_tc[0] = b0.tc;  assign d_wrap[0] = b0.wrap;  assign d_ovf[0] = b0.ovf;
  assign d_out[1] = b1.out;  assign d_tc[1] = b1.tc;  assign d_wrap[1] = b1.wrap;  assign d_ovf[1] = b1.ovf;
  assign d_out[2] = b2.out;  assign d_tc[2] = b2.tc;  assign d_wrap[2] = b2.wrap;  assign d_ovf[2] = b2.ovf;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: modular arithmetic for wrap mode, clamping for saturate.
  int MAXV [3] = '{15, 9, 9};
  bit SATV [3] = '{1'b0, 1'b0, 1'b1};
  int m_out [3];
  bit m_wrap [3];
  bit m_ovf [3];

  function automatic int model_next(input int m, input int mx, input bit sat, input bit dir);
    if (sat) return dir ? ((m + 1 > mx) ? mx : m + 1) : ((m - 1 < 0) ? 0 : m - 1);
    return dir ? ((m + 1) % (mx + 1)) : ((m + mx) % (mx + 1));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n || clear) begin
        m_out[k]  <= 0;
        m_wrap[k] <= 1'b0;
        m_ovf[k]  <= 1'b0;
      end else if (load) begin
        m_out[k]  <= (int'(load_val) > MAXV[k]) ? MAXV[k] : int'(load_val);
        m_wrap[k] <= 1'b0;
      end else if (en) begin
        m_out[k]  <= model_next(m_out[k], MAXV[k], SATV[k], up);
        m_wrap[k] <= up ? (m_out[k] == MAXV[k]) : (m_out[k] == 0);
        if (up ? (m_out[k] == MAXV[k]) : (m_out[k] == 0)) m_ovf[k] <= 1'b1;
      end else begin
        m_wrap[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("out%0d", k),  32'(d_out[k]),  32'(m_out[k]));
        check($sformatf("tc%0d", k),   32'(d_tc[k]),   32'(up ? (m_out[k] == MAXV[k]) : (m_out[k] == 0)));
        check($sformatf("wrap%0d", k), 32'(d_wrap[k]), 32'(m_wrap[k]));
        check($sformatf("ovf%0d", k),  32'(d_ovf[k]),  32'(m_ovf[k]));
      end
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic drive(input bit rn, input bit e, input bit u, input bit c, input bit l, input logic [3:0] v);
    reset_n = rn; en = e; up = u; clear = c; load = l; load_val = v;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int e2_out  [5] = '{2, 1, 0, 9, 8};
  bit e2_wrap [5] = '{0, 0, 0, 1, 0};
  bit e2_tc   [5] = '{0, 0, 1, 0, 0};
  bit e2_ovf  [5] = '{0, 0, 0, 1, 1};
  int e3_out  [5] = '{8, 9, 9, 9, 9};
  bit e3_wrap [5] = '{0, 0, 1, 1, 1};

  initial begin
    reset_n = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;

    // 1: reset, then free-running up count on the default configuration
    drive(0, 0, 1, 0, 0, 0);
    chk_on = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    check("rst_out",  32'(d_out[0]),  0);
    check("rst_wrap", 32'(d_wrap[0]), 0);
    check("rst_ovf",  32'(d_ovf[0]),  0);
    for (int i = 1; i <= 19; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      check("t1_out",  32'(d_out[0]),  32'(i % 16));
      check("t1_wrap", 32'(d_wrap[0]), 32'(i == 16));
      check("t1_tc",   32'(d_tc[0]),   32'(i == 15));
    end
    check("t1_ovf", 32'(d_ovf[0]), 1);

    // 2: MAX=9 down count through zero
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 3);
    check("t2_load", 32'(d_out[1]), 3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      check("t2_out",  32'(d_out[1]),  32'(e2_out[i]));
      check("t2_wrap", 32'(d_wrap[1]), 32'(e2_wrap[i]));
      check("t2_tc",   32'(d_tc[1]),   32'(e2_tc[i]));
      check("t2_ovf",  32'(d_ovf[1]),  32'(e2_ovf[i]));
    end

    // 3: saturate mode from 7 upward, then one step down
    drive(1, 0, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 7);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0);
      check("t3_out",  32'(d_out[2]),  32'(e3_out[i]));
      check("t3_wrap", 32'(d_wrap[2]), 32'(e3_wrap[i]));
    end
    check("t3_ovf", 32'(d_ovf[2]), 1);
    drive(1, 1, 0, 0, 0, 0);
    check("t3_dn_out",  32'(d_out[2]),  8);
    check("t3_dn_wrap", 32'(d_wrap[2]), 0);
    check("t3_dn_ovf",  32'(d_ovf[2]),  1);

    // 4: clear beats load and en; load clamps; load at MAX suppresses wrap
    drive(1, 1, 1, 1, 1, 5);
    check("t4_clr_out", 32'(d_out[1]), 0);
    check("t4_clr_ovf", 32'(d_ovf[1]), 0);
    drive(1, 0, 1, 0, 1, 12);
    check("t4_clamp",   32'(d_out[1]), 9);
    check("t4_noclamp", 32'(d_out[0]), 12);
    drive(1, 1, 1, 0, 1, 9);
    check("t4_ld_out",  32'(d_out[1]),  9);
    check("t4_ld_wrap", 32'(d_wrap[1]), 0);
    check("t4_ld_ovf",  32'(d_ovf[1]),  0);

    // 5: reset while counting with ovf set
    drive(1, 0, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 9);
    for (int i = 0; i < 7; i++) drive(1, 1, 1, 0, 0, 0);
    check("t5_pre_out", 32'(d_out[1]), 6);
    check("t5_pre_ovf", 32'(d_ovf[1]), 1);
    drive(0, 1, 1, 0, 0, 0);
    check("t5_rst_out",  32'(d_out[1]),  0);
    check("t5_rst_wrap", 32'(d_wrap[1]), 0);
    check("t5_rst_ovf",  32'(d_ovf[1]),  0);
    drive(1, 1, 1, 0, 0, 0);
    check("t5_out1", 32'(d_out[1]), 1);
    drive(1, 1, 1, 0, 0, 0);
    check("t5_out2", 32'(d_out[1]), 2);

    // 6: direction flip and enable gating; tc follows live up
    drive(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 0);
    check("t6_top", 32'(d_out[1]), 4);
    drive(1, 1, 0, 0, 0, 0);
    check("t6_a", 32'(d_out[1]), 3);
    drive(1, 0, 0, 0, 0, 0);
    check("t6_b", 32'(d_out[1]), 3);
    drive(1, 1, 0, 0, 0, 0);
    check("t6_c", 32'(d_out[1]), 2);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    check("t6_zero",  32'(d_out[1]), 0);
    check("t6_tc_dn", 32'(d_tc[1]),  1);
    up = 1'b1;
    #1;
    check("t6_tc_up", 32'(d_tc[1]), 0);
    up = 1'b0;
    #1;
    check("t6_tc_dn2", 32'(d_tc[1]), 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
